uart_tx_frame: RTL



---
 rtl/uart_tx_frame.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            dbg_state
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_TWO_STOP_EN
  localparam logic LAST_STOP = 1'b1;
`else
  localparam logic LAST_STOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap;

  assign wrap = (baud_q == BAUD_MAX);

  // Next-state logic; outputs are derived from the next state so they are registered
  // and line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop_d    = stop_q;

    if (state_q != S_IDLE) begin
      baud_d = wrap ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (data_valid) begin
          state_d   = S_START;
          shift_d   = p_data;
          par_bit_d = par_typ ? ~^p_data : ^p_data;
          par_en_d  = par_en;
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (stop_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_MAX) && (stop_d == LAST_STOP);
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule
